// File: rtl/addsub_nibble_sched.sv
// Two-requester add/subtract unit sharing one 4-bit adder, one nibble per clock, LSB first.
// Accept to rsp_valid takes NIBBLES edges; the result holds in DONE until rsp_ready.
module addsub_nibble_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_m,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_m,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            id_q, id_d;
    logic            m_q, m_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;

    logic            gnt;
    logic            accept;
    logic [3:0]      bx;
    logic [4:0]      nib;
    logic            c3;

    // Pointer only matters under contention; a lone requester always wins.
    assign gnt        = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    assign req0_ready = rst_n & (state_q == IDLE) & req0_valid & ~gnt;
    assign req1_ready = rst_n & (state_q == IDLE) & req1_valid & gnt;
    assign accept     = req0_ready | req1_ready;

    // Operands shift right each RUN cycle, so the active nibble is always bits [3:0].
    assign bx  = b_q[3:0] ^ {4{m_q}};
    assign nib = {1'b0, a_q[3:0]} + {1'b0, bx} + {4'b0, carry_q};
    assign c3  = nib[3] ^ a_q[3] ^ bx[3];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        m_d     = m_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = gnt ? req1_a : req0_a;
                    b_d     = gnt ? req1_b : req0_b;
                    m_d     = gnt ? req1_m : req0_m;
                    carry_d = gnt ? req1_m : req0_m;
                    id_d    = gnt;
                    ptr_d   = ~gnt;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                sum_d   = (sum_q >> 4) | (W'(nib[3:0]) << (W - 4));
                carry_d = nib[4];
                ovf_d   = c3 ^ nib[4];
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_nibble_sched.sv
// Directed bench for addsub_nibble_sched: arithmetic vectors, latency, back-pressure,
// mid-operation reset and round-robin contention.
module tb_addsub_nibble_sched;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_m;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_m;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
    logic [W-1:0] rsp_sum;

    int checks = 0;
    int errors = 0;

    addsub_nibble_sched #(.NIBBLES(NIB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the unit idle.
    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int stall, input string tag);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_m = m;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_m = m;
        end
        #1;
        chk({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (NIB - 1) @(negedge clk);
        chk({tag, "_early"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_sum"}, 32'(rsp_sum), 32'(es));
        chk({tag, "_cout"}, 32'(rsp_cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(eo));
        for (int i = 0; i < stall; i++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(rsp_sum), 32'(es));
            chk({tag, "_hold_id"}, 32'(rsp_id), 32'(id));
            chk({tag, "_hold_flags"}, 32'({rsp_cout, rsp_ovf}), 32'({ec, eo}));
            chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
            chk({tag, "_hold_rdy"}, 32'({req1_ready, req0_ready}), 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_released"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic       order [4];
    int         ng;
    logic       prev_any;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_m = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_m = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) order[i] = 1'bx;

        // Reset state, including a pending request that must not see ready.
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", 32'({rsp_id, rsp_cout, rsp_ovf}), 32'd0);
        chk("rst_sum", 32'(rsp_sum), 32'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;

        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, "add");
        do_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "sub_neg");
        do_op(1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 0, "sub_pos");
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "add_ovf");
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_wrap");
        do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_ovf");
        do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 10, "bp");

        // Reset while the third nibble is pending.
        req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_m = 1'b0;
        #1;
        chk("mid_ready", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_run", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(rsp_valid), 32'd0);
        chk("mid_outs", 32'({rsp_id, rsp_cout, rsp_ovf, req0_ready, req1_ready}), 32'd0);
        chk("mid_sum", 32'(rsp_sum), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'({rsp_valid, busy}), 32'd0);
        end
        do_op(1'b1, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0, "post_rst");

        // Contention from reset: both requesters hold valid, consumer always ready.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_m = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0001; req1_m = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("cont_rst_rdy", 32'({req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ng = 0;
        prev_any = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            chk("cont_busy_rdy", 32'(busy & (req0_ready | req1_ready)), 32'd0);
            chk("cont_onehot", 32'(req0_ready & req1_ready), 32'd0);
            chk("cont_pulse", 32'(prev_any & (req0_ready | req1_ready)), 32'd0);
            if ((req0_ready | req1_ready) && ng < 4) begin
                order[ng] = req1_ready;
                ng++;
            end
            prev_any = req0_ready | req1_ready;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_grants", 32'(ng), 32'd4);
        chk("cont_g0", 32'(order[0]), 32'd0);
        chk("cont_g1", 32'(order[1]), 32'd1);
        chk("cont_g2", 32'(order[2]), 32'd0);
        chk("cont_g3", 32'(order[3]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
